// File: rtl/mole_hit_judge_pkg.sv
// Shared types and helpers for the whack-a-mole judge: FSM states, LFSR taps, BCD math.
package mole_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SPAWN,
    UP,
    HIT,
    MISS,
    NEXT,
    OVER
  } state_t;

  // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v == 8'h99) return v;
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] to_bcd(input int unsigned v);
    int unsigned c;
    c = (v > 99) ? 99 : v;
    return {4'(c / 10), 4'(c % 10)};
  endfunction

endpackage

// File: rtl/mole_hit_judge_if.sv
// Key/start inputs and LED/score outputs of the mole judge, grouped as one bus.
interface mole_hit_judge_if;
  logic [7:0] key_in;
  logic       start;
  logic [7:0] mole_led;
  logic       hit_pulse;
  logic       miss_pulse;
  logic [7:0] score_bcd;
  logic [7:0] miss_bcd;
  logic [7:0] round_bcd;
  logic       game_over;

  modport master (
    output key_in, start,
    input  mole_led, hit_pulse, miss_pulse, score_bcd, miss_bcd, round_bcd, game_over
  );

  modport slave (
    input  key_in, start,
    output mole_led, hit_pulse, miss_pulse, score_bcd, miss_bcd, round_bcd, game_over
  );
endinterface

// File: rtl/mole_hit_judge_key_press_detect.sv
// Turns the scanner's flickering one-hot key code into single press events;
// re-arms only after RELEASE_CYC consecutive idle cycles.
module key_press_detect #(
  parameter int unsigned RELEASE_CYC = 250_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] key_in,
  output logic       press_evt,
  output logic [7:0] press_code
);

  localparam int unsigned CW   = (RELEASE_CYC > 2) ? $clog2(RELEASE_CYC) : 1;
  localparam logic [CW-1:0] ZMAX = CW'(RELEASE_CYC - 1);

  logic          armed;
  logic [CW-1:0] zcnt;
  logic          one_hot;

  assign one_hot = (key_in != '0) && ((key_in & (key_in - 8'd1)) == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      armed      <= 1'b1;
      zcnt       <= '0;
      press_evt  <= 1'b0;
      press_code <= '0;
    end else begin
      press_evt <= 1'b0;
      if (key_in == '0) begin
        // counter saturates at ZMAX and keeps re-asserting armed
        if (zcnt == ZMAX) armed <= 1'b1;
        else              zcnt  <= zcnt + 1'b1;
      end else begin
        zcnt <= '0;
        if (armed && one_hot) begin
          press_evt  <= 1'b1;
          press_code <= key_in;
          armed      <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/mole_hit_judge.sv
// Whack-a-mole round FSM: spawns moles, times the window, judges presses, keeps BCD counts.
// Optional MOLE_SPEEDUP_EN shortens the mole window after every 5th hit.
module mole_hit_judge
  import mole_pkg::*;
#(
  parameter int unsigned UP_CYC      = 50_000_000,
  parameter int unsigned FB_CYC      = 12_500_000,
  parameter int unsigned RELEASE_CYC = 250_000,
  parameter int unsigned ROUNDS      = 30,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input logic              clk,
  input logic              rst,
  mole_hit_judge_if.slave  bus
);

  localparam int unsigned TMAX = (UP_CYC > FB_CYC) ? UP_CYC : FB_CYC;
  localparam int unsigned TW   = $clog2(TMAX + 1);
  localparam logic [7:0]  ROUNDS_BCD = to_bcd(ROUNDS);

  state_t        state, state_next;
  logic [TW-1:0] timer;
  logic [TW-1:0] up_load;
  logic [15:0]   lfsr;
  logic [2:0]    hole, hole_cand;
  logic [7:0]    mole_onehot;
  logic          press_evt;
  logic [7:0]    press_code;
  logic [7:0]    score, misses, round;
  logic          hit_q, miss_q;

  key_press_detect #(.RELEASE_CYC(RELEASE_CYC)) u_kpd (
    .clk        (clk),
    .rst        (rst),
    .key_in     (bus.key_in),
    .press_evt  (press_evt),
    .press_code (press_code)
  );

  // avoid showing the mole in the same hole twice in a row
  assign hole_cand   = (lfsr[2:0] == hole) ? lfsr[2:0] + 3'd1 : lfsr[2:0];
  assign mole_onehot = 8'd1 << hole;

`ifdef MOLE_SPEEDUP_EN
  logic [TW-1:0] up_len, up_shrunk;
  logic [2:0]    hit_mod;

  always_comb begin
    up_shrunk = up_len - (up_len >> 3);
    if (up_shrunk < TW'(UP_CYC >> 2)) up_shrunk = TW'(UP_CYC >> 2);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      up_len  <= TW'(UP_CYC);
      hit_mod <= '0;
    end else if (state == IDLE) begin
      up_len  <= TW'(UP_CYC);
      hit_mod <= '0;
    end else if (state == UP && state_next == HIT) begin
      if (hit_mod == 3'd4) begin
        hit_mod <= '0;
        up_len  <= up_shrunk;
      end else begin
        hit_mod <= hit_mod + 3'd1;
      end
    end
  end

  assign up_load = up_len - 1'b1;
`else
  assign up_load = TW'(UP_CYC - 1);
`endif

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  if (bus.start) state_next = SPAWN;
      SPAWN: state_next = UP;
      UP: begin
        // a press on the timeout cycle takes priority over the timeout
        if (press_evt)          state_next = (press_code == mole_onehot) ? HIT : MISS;
        else if (timer == '0)   state_next = MISS;
      end
      HIT, MISS: if (timer == '0) state_next = NEXT;
      NEXT:  state_next = (round == ROUNDS_BCD) ? OVER : SPAWN;
      OVER:  if (bus.start) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.mole_led  = '0;
    bus.game_over = 1'b0;
    if (state == UP)   bus.mole_led  = mole_onehot;
    if (state == OVER) bus.game_over = 1'b1;
  end

  assign bus.hit_pulse  = hit_q;
  assign bus.miss_pulse = miss_q;
  assign bus.score_bcd  = score;
  assign bus.miss_bcd   = misses;
  assign bus.round_bcd  = round;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr   <= LFSR_SEED;
      hole   <= '0;
      timer  <= '0;
      score  <= '0;
      misses <= '0;
      round  <= '0;
      hit_q  <= 1'b0;
      miss_q <= 1'b0;
    end else begin
      lfsr   <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
      hit_q  <= (state == UP) && (state_next == HIT);
      miss_q <= (state == UP) && (state_next == MISS);
      case (state)
        IDLE: if (state_next == SPAWN) begin
          score  <= '0;
          misses <= '0;
          round  <= '0;
        end
        SPAWN: begin
          hole  <= hole_cand;
          round <= bcd_inc(round);
          timer <= up_load;
        end
        UP: begin
          if (state_next == HIT) begin
            score <= bcd_inc(score);
            timer <= TW'(FB_CYC - 1);
          end else if (state_next == MISS) begin
            misses <= bcd_inc(misses);
            timer  <= TW'(FB_CYC - 1);
          end else begin
            timer <= timer - 1'b1;
          end
        end
        HIT, MISS: if (timer != '0) timer <= timer - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mole_hit_judge.sv
// Randomized bench for mole_hit_judge against a cycle-level behavioural game model.
module tb_mole_hit_judge;

  localparam int unsigned UP_CYC      = 100;
  localparam int unsigned FB_CYC      = 10;
  localparam int unsigned RELEASE_CYC = 8;
  localparam int unsigned ROUNDS      = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mole_hit_judge_if bus();

  mole_hit_judge #(
    .UP_CYC      (UP_CYC),
    .FB_CYC      (FB_CYC),
    .RELEASE_CYC (RELEASE_CYC),
    .ROUNDS      (ROUNDS),
    .LFSR_SEED   (16'hACE1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum {P_IDLE, P_SPAWN, P_UP, P_HIT, P_MISS, P_NEXT, P_OVER} ph_t;
  ph_t         ph;
  int unsigned age, hits, misses, rounds, zero_run, hole;
  bit          armed, pevt, hit_p, miss_p;
  logic [7:0]  pcode;
  logic [15:0] lfsr;

  function automatic logic [7:0] bcd(input int unsigned v);
    int unsigned c;
    c = (v > 99) ? 99 : v;
    return 8'((c / 10) * 16 + (c % 10));
  endfunction

  function automatic logic [7:0] mole_code();
    return 8'(1 << hole);
  endfunction

  task automatic model_reset();
    ph = P_IDLE; age = 0; hits = 0; misses = 0; rounds = 0; hole = 0;
    zero_run = 0; armed = 1; pevt = 0; pcode = '0; hit_p = 0; miss_p = 0;
    lfsr = 16'hACE1;
  endtask

  task automatic model_step(input logic [7:0] k, input logic s);
    bit          old_pevt;
    logic [7:0]  old_code;
    int unsigned cand;
    old_pevt = pevt;
    old_code = pcode;
    hit_p = 0;
    miss_p = 0;
    case (ph)
      P_IDLE: if (s) begin ph = P_SPAWN; hits = 0; misses = 0; rounds = 0; end
      P_SPAWN: begin
        cand = lfsr % 8;
        if (cand == hole) cand = (cand + 1) % 8;
        hole = cand; rounds++; age = 0; ph = P_UP;
      end
      P_UP: begin
        if (old_pevt) begin
          if (old_code == mole_code()) begin hits++; hit_p = 1; ph = P_HIT; end
          else begin misses++; miss_p = 1; ph = P_MISS; end
          age = 0;
        end else if (age == UP_CYC - 1) begin
          misses++; miss_p = 1; ph = P_MISS; age = 0;
        end else age++;
      end
      P_HIT, P_MISS: if (age == FB_CYC - 1) ph = P_NEXT; else age++;
      P_NEXT: ph = (rounds == ROUNDS) ? P_OVER : P_SPAWN;
      P_OVER: if (s) ph = P_IDLE;
      default: ph = P_IDLE;
    endcase
    pevt = 0;
    if (k == 8'h00) begin
      zero_run++;
      if (zero_run >= RELEASE_CYC) armed = 1;
    end else begin
      zero_run = 0;
      if (armed && $countones(k) == 1) begin pevt = 1; pcode = k; armed = 0; end
    end
    lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  endtask

  task automatic compare_all();
    check("mole_led",   32'(bus.mole_led),   (ph == P_UP) ? 32'(mole_code()) : 32'h0);
    check("hit_pulse",  32'(bus.hit_pulse),  32'(hit_p));
    check("miss_pulse", 32'(bus.miss_pulse), 32'(miss_p));
    check("score_bcd",  32'(bus.score_bcd),  32'(bcd(hits)));
    check("miss_bcd",   32'(bus.miss_bcd),   32'(bcd(misses)));
    check("round_bcd",  32'(bus.round_bcd),  32'(bcd(rounds)));
    check("game_over",  32'(bus.game_over),  32'(ph == P_OVER));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mole"},  32'(bus.mole_led),   32'h0);
    check({tag, "_hit"},   32'(bus.hit_pulse),  32'h0);
    check({tag, "_miss"},  32'(bus.miss_pulse), 32'h0);
    check({tag, "_score"}, 32'(bus.score_bcd),  32'h0);
    check({tag, "_mbcd"},  32'(bus.miss_bcd),   32'h0);
    check({tag, "_round"}, 32'(bus.round_bcd),  32'h0);
    check({tag, "_over"},  32'(bus.game_over),  32'h0);
  endtask

  // drive inputs for one cycle (called just after a negedge), then compare at the next negedge
  task automatic step(input logic [7:0] k, input logic s);
    bus.key_in = k;
    bus.start  = s;
    model_step(k, s);
    @(negedge clk);
    compare_all();
  endtask

  task automatic wait_up_age(input int unsigned target, input string tag);
    int unsigned n;
    n = 0;
    while (!(ph == P_UP && age == target) && n < 2000) begin
      step(8'h00, (ph == P_IDLE || ph == P_OVER));
      n++;
    end
    if (n >= 2000) check({tag, "_wait_timeout"}, 32'h0, 32'h1);
  endtask

  logic [7:0]  cur_key;
  int unsigned hold_left;
  int unsigned r;

  initial begin
    rst = 1'b0;
    bus.key_in = '0;
    bus.start  = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b1;

    // start a game: SPAWN then UP with round 1
    step(8'h00, 1'b1);
    step(8'h00, 1'b0);
    check("round_first", 32'(bus.round_bcd), 32'h01);
    check("mole_onehot", 32'($countones(bus.mole_led)), 32'd1);
    check("score_first", 32'(bus.score_bcd), 32'h00);

    // press arriving on the timeout cycle must be judged a hit
    wait_up_age(UP_CYC - 2, "tmo");
    step(mole_code(), 1'b0);
    step(8'h00, 1'b0);
    check("timeout_hit", 32'(bus.hit_pulse), 32'h1);

    // flickering hold of the correct key yields a single press
    wait_up_age(0, "hold");
    for (int i = 0; i < 40; i++) step(((i % 4) < 2) ? mole_code() : 8'h00, 1'b0);

    // multi-bit key code is ignored while the mole stays up
    wait_up_age(0, "multi");
    for (int i = 0; i < 12; i++) step(8'h81, 1'b0);
    check("multi_ignored", 32'($countones(bus.mole_led)), 32'd1);

    // randomized play
    hold_left = 0;
    cur_key = '0;
    for (int i = 0; i < 15000; i++) begin
      if (hold_left == 0) begin
        r = $urandom_range(99);
        hold_left = $urandom_range(12, 1);
        if (r < 40)      cur_key = 8'h00;
        else if (r < 70) cur_key = (ph == P_UP) ? mole_code() : 8'(1 << $urandom_range(7));
        else if (r < 85) cur_key = 8'(1 << $urandom_range(7));
        else if (r < 92) cur_key = 8'h81;
        else             cur_key = 8'($urandom_range(255));
      end
      hold_left--;
      step(cur_key, ($urandom_range(9) == 0));
    end

    // asynchronous reset mid-UP clears outputs immediately
    wait_up_age(20, "rst");
    rst = 1'b0;
    #1;
    check_all_zero("midrst");
    model_reset();
    bus.key_in = '0;
    bus.start  = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 300; i++) step(8'h00, (i % 50) == 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mole_hit_judge.md
Name: mole_hit_judge

Overview:
- Game-logic stage directly downstream of the keypad scanner.
- Consumes the scanner's 8-bit one-hot key code and turns it into clean single press events.
- Runs the whack-a-mole round FSM: picks a hole, times the mole window, judges each press as hit or miss, and keeps BCD score/miss counts.
- Outputs drive the mole LEDs and the score display stage.

Parameters:
- UP_CYC, 50_000_000, mole-visible window in clk cycles (1 s @ 50 MHz).
- FB_CYC, 12_500_000, hit/miss feedback hold in cycles.
- RELEASE_CYC, 250_000, consecutive zero-key cycles needed to re-arm (longer than one 4-phase scan period).
- ROUNDS, 30, moles per game (1..99).
- LFSR_SEED, 16'hACE1, non-zero LFSR reset seed.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- key_in  in  8  one-hot key code from scanner; may drop to 0 between scan phases while a key is held
- start  in  1  level; start game from IDLE/OVER
- mole_led  out  8  one-hot visible mole; 0 when none
- hit_pulse  out  1  one-cycle pulse on a judged hit
- miss_pulse  out  1  one-cycle pulse on a judged miss
- score_bcd  out  8  hits, two BCD digits, saturates at 99
- miss_bcd  out  8  misses, two BCD digits, saturates at 99
- round_bcd  out  8  current round number, BCD
- game_over  out  1  high in OVER

Behaviour:
- Reset: FSM=IDLE; all outputs 0; LFSR=LFSR_SEED; press detector armed; zero counter 0.
- Press detector:
  - press_evt asserts one cycle after a clk edge on which armed=1 and key_in is exactly one-hot; press_code latches key_in; armed clears.
  - Non-one-hot non-zero key_in: ignored; zero counter resets; armed is unchanged.
  - Zero counter counts consecutive key_in==0 cycles; on reaching RELEASE_CYC-1, armed sets and the counter holds.
  - Any non-zero key_in resets the counter.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11; advances every clk. Hole = LFSR[2:0]; if equal to the previous hole, use hole+1 mod 8.
- FSM states:
  - IDLE: start=1 -> SPAWN; clears score, misses, round.
  - SPAWN (1 cycle): latch hole; round_bcd += 1; load timer with UP_CYC-1 -> UP.
  - UP: mole_led = 1<<hole; timer decrements.
    - press_evt with press_code==mole_led -> HIT.
    - press_evt with any other code -> MISS.
    - timer==0 with no press -> MISS.
    - If press_evt and timer==0 occur in the same cycle, the press wins.
  - HIT: hit_pulse on entry cycle only; score +1 (BCD, saturate 99); mole_led=0; hold FB_CYC cycles -> NEXT.
  - MISS: miss_pulse on entry cycle only; misses +1 (saturate 99); mole_led=0; hold FB_CYC cycles -> NEXT.
  - NEXT (1 cycle): round==ROUNDS -> OVER, else SPAWN.
  - OVER: game_over=1; counts frozen; start=1 -> IDLE path, i.e. the next cycle is IDLE, which restarts the game.
- Press events outside UP are discarded, never queued.
- start outside IDLE/OVER is ignored.
- BCD increment: low digit 9 -> 0 with carry; 99 stays 99.
- Reset asserted mid-game returns everything to reset values asynchronously.

Optional Feature:
- Macro: MOLE_SPEEDUP_EN.
- Defined: after every 5th hit, the UP load value shrinks by (current>>3). The value is held in a register sized for UP_CYC and floors at UP_CYC>>2. It resets to UP_CYC in IDLE.
- Undefined: every round loads UP_CYC-1; the register and logic are absent.

Decomposition:
- Package mole_pkg holds:
  - FSM state enum (IDLE, SPAWN, UP, HIT, MISS, NEXT, OVER);
  - LFSR tap constant;
  - BCD increment/saturate function.
- One sub-module, key_press_detect: the arm/zero-counter/press_evt logic, parameterised by RELEASE_CYC.

Test Plan:
All scenarios use UP_CYC=100, FB_CYC=10, RELEASE_CYC=8, ROUNDS=3.
- Reset, then start=1 -> SPAWN next cycle; round_bcd=8'h01; mole_led one-hot; score_bcd=8'h00.
- In UP, drive key_in=mole_led for 3 cycles, then 0 -> hit_pulse once 2 cycles later; score_bcd=8'h01; FSM reaches SPAWN after 10 cycles.
- Hold the correct key with key_in alternating code/0/0/code every 2 cycles for 40 cycles -> only one press_evt; rearm only after 8 zero cycles.
- Press a wrong key (mole_led rotated by 1) -> miss_pulse; miss_bcd=8'h01; score unchanged.
- No press -> miss_pulse exactly 100 cycles after UP entry. After round 3: game_over=1, round_bcd=8'h03, and start reopens IDLE.
- Press arriving on the timeout cycle -> judged as a hit. key_in=8'h81 -> ignored. Reset pulse mid-UP -> all outputs 0 at once.
